dataflow_ctrl: RTL and testbench
================================

Name: dataflow_ctrl

Overview:
Sequencing control unit that sits directly upstream of the 64-bit dataflow (register file, add/sub adder, operand mux, data memory, writeback mux). It accepts one command at a time over a valid/ready handshake. It then drives every select, address and write-enable of the dataflow through a fixed multi-cycle sequence that matches the registered read latency of the register file and the memory. Supported commands are register ADD/SUB, LOAD and STORE.

Parameters:
DATA_W, 64, width of datapath and of the C constant output
IMM_W, 12, width of the signed immediate in a command
CNT_W, 16, width of the completed-command counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  controller can accept a command (high only in IDLE)
cmd_op  in  2  00 ADD, 01 SUB, 10 LOAD, 11 STORE
cmd_rd  in  5  destination register
cmd_ra  in  5  source register A (base register for LOAD/STORE)
cmd_rb  in  5  source register B (store data for STORE)
cmd_imm  in  IMM_W  signed offset for LOAD/STORE
Ra  out  5  register file read port A
Rb  out  5  register file read port B
Rw  out  5  register file write address
reg_we  out  1  register file write enable
mem_we  out  1  data memory write enable
sinal  out  1  adder op: 0 add, 1 subtract
sinal_mux1  out  1  adder B operand select: 0 C constant, 1 register Rb
sinal_mux2  out  1  writeback select: 0 memory dout, 1 adder soma
C  out  DATA_W  cmd_imm sign-extended to DATA_W
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when a command completes
instr_count  out  CNT_W  number of completed commands

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset: state=IDLE and latched command fields (op, rd, ra, rb, imm) cleared to 0. Outputs while rst_n is low and after release:
  - cmd_ready=1, busy=0, done=0
  - Ra=Rb=Rw=0, reg_we=0, mem_we=0
  - sinal=0, sinal_mux1=0, sinal_mux2=0
  - C=0, instr_count=0
- Accept: in IDLE with cmd_valid=1, the fields are latched at the rising edge and the state goes to RD. cmd_valid is ignored outside IDLE.
- Outputs are Moore outputs, decoded from the state and latched fields only; no cmd_* input reaches an output combinationally.
- Ra, Rb, Rw, C, sinal and sinal_mux1 are held stable from RD through FIM.
- States and sequence:
  - IDLE: cmd_ready=1; all enables 0.
  - RD: Ra=ra, Rb=rb, reg_we=0, mem_we=0. The register file captures doutA/doutB at the end of this cycle.
  - EX: sinal=1 only for SUB. sinal_mux1=1 for ADD/SUB, 0 for LOAD/STORE (address = Ra + C; memory address is soma[5:0], wired externally). ADD/SUB go to WB; LOAD/STORE go to MEM.
  - MEM:
    - LOAD: mem_we=0, memory dout is captured at the end of the cycle; next state WB.
    - STORE: mem_we=1 for exactly this cycle (din = doutB, wired externally); next state FIM.
  - WB: reg_we=1 for exactly one cycle, Rw=rd. sinal_mux2=1 for ADD/SUB, 0 for LOAD. Next state FIM.
  - FIM: done=1, instr_count increments by 1 (wraps from 2^CNT_W-1 to 0), all enables 0; next state IDLE.
- Latency from the accept edge to done high: ADD/SUB 4 cycles, LOAD 5, STORE 4.
- Throughput: the next command can be accepted in the IDLE cycle after FIM; no back-to-back overlap.
- reg_we and mem_we are never high together. Neither is ever high in IDLE, RD or FIM.
- rd=0 is an ordinary writable register (no hardwired zero).
- Reset mid-command: the sequence aborts immediately and the block returns to the reset values. A pending write enable drops asynchronously. instr_count is cleared.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, release -> cmd_ready=1, busy=0, all enables 0, C=0, instr_count=0.
- ADD: cmd op=00, rd=2, ra=0, rb=1 -> RD cycle Ra=0, Rb=1; EX sinal=0, sinal_mux1=1; WB reg_we=1, Rw=2, sinal_mux2=1; done 4 cycles after accept; instr_count=1. With the dataflow attached, r2 reads 1.
- SUB: op=01, rd=3, ra=1, rb=1 -> sinal=1 from EX through FIM; r3 reads 0; done after 4 cycles.
- LOAD: op=10, rd=4, ra=0, imm=1 -> C=1, sinal_mux1=0, mem_we=0 throughout, WB sinal_mux2=0, reg_we=1; r4 reads 11 (memory word 1); done after 5 cycles.
- STORE: op=11, ra=0, rb=1, imm=-1 (0xFFF) -> C=0xFFFF_FFFF_FFFF_FFFF; mem_we=1 for exactly 1 cycle; reg_we never 1; done after 4 cycles.
- Boundaries:
  - cmd_valid held high continuously -> accepts occur only in IDLE, exactly one command per sequence.
  - rst_n pulsed low during WB -> reg_we drops asynchronously, state=IDLE, instr_count=0.
  - Preload instr_count to 0xFFFF -> the next done wraps it to 0.

Source files
------------

// File: rtl/dataflow_ctrl_if.sv
// Command handshake between a command source and the dataflow sequencer.
// The master supplies one command; the slave raises cmd_ready when it can take it.
interface dataflow_ctrl_if #(
    parameter int IMM_W = 12
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [4:0]       cmd_rd;
    logic [4:0]       cmd_ra;
    logic [4:0]       cmd_rb;
    logic [IMM_W-1:0] cmd_imm;

    modport master (
        output cmd_valid, cmd_op, cmd_rd, cmd_ra, cmd_rb, cmd_imm,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_rd, cmd_ra, cmd_rb, cmd_imm,
        output cmd_ready
    );
endinterface

// File: rtl/dataflow_ctrl.sv
// Sequencer for the 64-bit register-file/adder/memory dataflow: takes one
// ADD/SUB/LOAD/STORE command and walks it through RD, EX, MEM, WB and FIM.
module dataflow_ctrl #(
    parameter int DATA_W = 64,
    parameter int IMM_W  = 12,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    dataflow_ctrl_if.slave    cmd,
    output logic [4:0]        Ra,
    output logic [4:0]        Rb,
    output logic [4:0]        Rw,
    output logic              reg_we,
    output logic              mem_we,
    output logic              sinal,
    output logic              sinal_mux1,
    output logic              sinal_mux2,
    output logic [DATA_W-1:0] C,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  instr_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_EX, S_MEM, S_WB, S_FIM
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD, OP_SUB, OP_LOAD, OP_STORE
    } op_t;

    state_t           r_state;
    state_t           w_next;
    op_t              r_op;
    logic [4:0]       r_rd;
    logic [4:0]       r_ra;
    logic [4:0]       r_rb;
    logic [IMM_W-1:0] r_imm;
    logic [CNT_W-1:0] r_count;
    logic             w_ready;
    logic             w_busy;
    logic             w_mem_op;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_op    <= OP_ADD;
            r_rd    <= '0;
            r_ra    <= '0;
            r_rb    <= '0;
            r_imm   <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && cmd.cmd_valid) begin
                r_op  <= op_t'(cmd.cmd_op);
                r_rd  <= cmd.cmd_rd;
                r_ra  <= cmd.cmd_ra;
                r_rb  <= cmd.cmd_rb;
                r_imm <= cmd.cmd_imm;
            end
            if (r_state == S_FIM)
                r_count <= r_count + 1'b1;
        end
    end

    // LOAD and STORE share the memory path: address = Ra + C.
    assign w_mem_op = (r_op == OP_LOAD) || (r_op == OP_STORE);

    always_comb begin
        w_next     = r_state;
        w_ready    = 1'b0;
        reg_we     = 1'b0;
        mem_we     = 1'b0;
        sinal_mux2 = 1'b0;
        done       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (cmd.cmd_valid)
                    w_next = S_RD;
            end
            S_RD:  w_next = S_EX;
            S_EX:  w_next = w_mem_op ? S_MEM : S_WB;
            S_MEM: begin
                if (r_op == OP_STORE) begin
                    mem_we = 1'b1;
                    w_next = S_FIM;
                end else begin
                    w_next = S_WB;
                end
            end
            S_WB: begin
                reg_we     = 1'b1;
                sinal_mux2 = !w_mem_op;
                w_next     = S_FIM;
            end
            S_FIM: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Operand selects stay put for the whole command so the adder output
    // is settled in whichever cycle samples it.
    assign w_busy     = (r_state != S_IDLE);
    assign busy       = w_busy;
    assign sinal      = w_busy && (r_op == OP_SUB);
    assign sinal_mux1 = w_busy && !w_mem_op;
    assign Ra         = r_ra;
    assign Rb         = r_rb;
    assign Rw         = r_rd;
    assign C          = {{(DATA_W-IMM_W){r_imm[IMM_W-1]}}, r_imm};
    assign instr_count = r_count;
    assign cmd.cmd_ready = w_ready;

endmodule

// File: tb/tb_dataflow_ctrl.sv
// Bench for dataflow_ctrl: hand-written vector table, randomized commands
// scored against a rule-level model, plus reset and counter-wrap corners.
module tb_dataflow_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dataflow_ctrl_if #(.IMM_W(12)) cif ();
    dataflow_ctrl_if #(.IMM_W(12)) cif2 ();

    logic [4:0]  Ra, Rb, Rw;
    logic        reg_we, mem_we, sinal, sinal_mux1, sinal_mux2, busy, done;
    logic [63:0] C;
    logic [15:0] instr_count;

    logic [4:0]  d2_Ra, d2_Rb, d2_Rw;
    logic        d2_reg_we, d2_mem_we, d2_sinal, d2_mux1, d2_mux2, d2_busy, d2_done;
    logic [63:0] d2_C;
    logic [2:0]  d2_count;

    dataflow_ctrl #(.DATA_W(64), .IMM_W(12), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .cmd(cif.slave),
        .Ra(Ra), .Rb(Rb), .Rw(Rw), .reg_we(reg_we), .mem_we(mem_we),
        .sinal(sinal), .sinal_mux1(sinal_mux1), .sinal_mux2(sinal_mux2),
        .C(C), .busy(busy), .done(done), .instr_count(instr_count)
    );

    // Narrow-counter copy fed the same commands, so the wrap is reachable.
    assign cif2.cmd_valid = cif.cmd_valid;
    assign cif2.cmd_op    = cif.cmd_op;
    assign cif2.cmd_rd    = cif.cmd_rd;
    assign cif2.cmd_ra    = cif.cmd_ra;
    assign cif2.cmd_rb    = cif.cmd_rb;
    assign cif2.cmd_imm   = cif.cmd_imm;

    dataflow_ctrl #(.DATA_W(64), .IMM_W(12), .CNT_W(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .cmd(cif2.slave),
        .Ra(d2_Ra), .Rb(d2_Rb), .Rw(d2_Rw), .reg_we(d2_reg_we), .mem_we(d2_mem_we),
        .sinal(d2_sinal), .sinal_mux1(d2_mux1), .sinal_mux2(d2_mux2),
        .C(d2_C), .busy(d2_busy), .done(d2_done), .instr_count(d2_count)
    );

    typedef struct {
        logic [1:0]  op;
        logic [4:0]  rd, ra, rb;
        logic [11:0] imm;
        int          lat, nreg, nmem, pos;
        logic [63:0] c;
        logic        sinal, mux1, mux2;
    } vec_t;

    int n_pass = 0;
    int n_tot  = 0;
    int cnt    = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        else
            n_pass++;
    endtask

    // Reference rules: cycle counts by command class, C by two's-complement value.
    function automatic vec_t model(input logic [1:0] op, input logic [4:0] rd,
                                   input logic [4:0] ra, input logic [4:0] rb,
                                   input logic [11:0] imm);
        vec_t v;
        v.op = op; v.rd = rd; v.ra = ra; v.rb = rb; v.imm = imm;
        v.lat   = (op == 2'd2) ? 5 : 4;
        v.nreg  = (op == 2'd3) ? 0 : 1;
        v.nmem  = (op == 2'd3) ? 1 : 0;
        v.pos   = (op == 2'd2) ? 4 : 3;
        v.c     = (imm >= 12'd2048) ? (64'(imm) - 64'd4096) : 64'(imm);
        v.sinal = (op == 2'd1);
        v.mux1  = (op < 2'd2);
        v.mux2  = (op < 2'd2);
        return v;
    endfunction

    // Entered just after a negedge with the DUT idle; returns one negedge into
    // the following idle cycle.
    task automatic run_cmd(input vec_t v, input bit hold);
        int lat, nreg, nmem, pos, bad, conf;
        logic mux2v;
        lat = 0; nreg = 0; nmem = 0; pos = 0; bad = 0; conf = 0; mux2v = 1'b0;
        cif.cmd_op = v.op; cif.cmd_rd = v.rd; cif.cmd_ra = v.ra;
        cif.cmd_rb = v.rb; cif.cmd_imm = v.imm; cif.cmd_valid = 1'b1;
        chk("accept_ready", 64'(cif.cmd_ready), 64'd1);
        @(posedge clk);
        for (int n = 1; n <= 10 && lat == 0; n++) begin
            @(negedge clk);
            if (n == 1 && !hold) cif.cmd_valid = 1'b0;
            if (!busy || cif.cmd_ready) bad++;
            if (Ra !== v.ra || Rb !== v.rb || Rw !== v.rd || C !== v.c ||
                sinal !== v.sinal || sinal_mux1 !== v.mux1) bad++;
            if (reg_we && mem_we) conf++;
            if (reg_we) begin nreg++; pos = n; mux2v = sinal_mux2; end
            if (mem_we) begin nmem++; pos = n; end
            if (done) lat = n;
        end
        chk("latency",     64'(lat),  64'(v.lat));
        chk("reg_we_cyc",  64'(nreg), 64'(v.nreg));
        chk("mem_we_cyc",  64'(nmem), 64'(v.nmem));
        chk("we_position", 64'(pos),  64'(v.pos));
        chk("we_overlap",  64'(conf), 64'd0);
        chk("held_fields", 64'(bad),  64'd0);
        chk("wb_mux2",     64'(mux2v), 64'(v.mux2 && v.nreg == 1));
        cnt++;
        @(negedge clk);
        chk("idle_after",  64'({busy, cif.cmd_ready}), 64'b01);
        chk("instr_count", 64'(instr_count), 64'(cnt % 65536));
        chk("count_wrap3", 64'(d2_count),    64'(cnt % 8));
    endtask

    vec_t tbl [6];

    initial begin
        tbl[0] = '{2'd0, 5'd2,  5'd0,  5'd1, 12'h000, 4, 1, 0, 3, 64'h0,                 1'b0, 1'b1, 1'b1};
        tbl[1] = '{2'd1, 5'd3,  5'd1,  5'd1, 12'h000, 4, 1, 0, 3, 64'h0,                 1'b1, 1'b1, 1'b1};
        tbl[2] = '{2'd2, 5'd4,  5'd0,  5'd0, 12'h001, 5, 1, 0, 4, 64'h1,                 1'b0, 1'b0, 1'b0};
        tbl[3] = '{2'd3, 5'd0,  5'd0,  5'd1, 12'hFFF, 4, 0, 1, 3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{2'd0, 5'd0,  5'd31, 5'd31, 12'h7FF, 4, 1, 0, 3, 64'h7FF,              1'b0, 1'b1, 1'b1};
        tbl[5] = '{2'd2, 5'd31, 5'd5,  5'd9, 12'h800, 5, 1, 0, 4, 64'hFFFF_FFFF_FFFF_F800, 1'b0, 1'b0, 1'b0};

        rst_n = 1'b0;
        cif.cmd_valid = 1'b0; cif.cmd_op = '0; cif.cmd_rd = '0;
        cif.cmd_ra = '0; cif.cmd_rb = '0; cif.cmd_imm = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready_busy", 64'({cif.cmd_ready, busy, done}), 64'b100);
        chk("rst_enables", 64'({reg_we, mem_we, sinal, sinal_mux1, sinal_mux2}), 64'd0);
        chk("rst_regs", 64'({Ra, Rb, Rw}), 64'd0);
        chk("rst_C", C, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 64'({cif.cmd_ready, busy}), 64'b10);
        chk("post_rst_count", 64'(instr_count), 64'd0);

        for (int i = 0; i < 6; i++) run_cmd(tbl[i], 1'b0);

        // cmd_valid never drops across three commands
        for (int i = 0; i < 3; i++) run_cmd(tbl[i+1], 1'b1);
        cif.cmd_valid = 1'b0;
        @(negedge clk);
        chk("hold_no_extra", 64'({busy, instr_count}), 64'(cnt % 65536));

        for (int i = 0; i < 60; i++) begin
            vec_t v;
            v = model(2'($urandom_range(3)), 5'($urandom), 5'($urandom),
                      5'($urandom), 12'($urandom));
            repeat ($urandom_range(2)) @(negedge clk);
            run_cmd(v, 1'($urandom_range(1)));
            cif.cmd_valid = 1'b0;
        end

        // Abort during WB
        cif.cmd_op = 2'd0; cif.cmd_rd = 5'd5; cif.cmd_ra = 5'd6;
        cif.cmd_rb = 5'd7; cif.cmd_imm = 12'h123; cif.cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cif.cmd_valid = 1'b0;
        for (int n = 0; n < 6 && !reg_we; n++) @(negedge clk);
        chk("reach_wb", 64'(reg_we), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_reg_we", 64'({reg_we, mem_we, done}), 64'd0);
        chk("abort_idle", 64'({cif.cmd_ready, busy}), 64'b10);
        chk("abort_count", 64'(instr_count), 64'd0);
        chk("abort_fields", 64'({Ra, Rb, Rw}), 64'd0);
        chk("abort_C", C, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        @(negedge clk);
        chk("abort_count2", 64'(d2_count), 64'd0);
        run_cmd(tbl[3], 1'b0);
        run_cmd(tbl[2], 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
